alu_seq_calc: RTL



---
 rtl/alu_seq_calc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq_calc.sv
// Button-driven sequential calculator: captures op, A and B from the switches,
// then executes add, sign/magnitude subtract, shift-add multiply or right shift.
module alu_seq_calc #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic               CLK100MHZ,
    input  logic               Reset,
    input  logic               Center,
    input  logic [WIDTH-1:0]   SW,
    output logic [2*WIDTH-1:0] result,
    output logic               negative,
    output logic [3:0]         LED,
    output logic               busy,
    output logic               done,
    output logic [2:0]         stage
);

    localparam int RW = 2 * WIDTH;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_SEL  = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [RW-1:0]    result_q, result_d;
    logic [RW-1:0]    mcand_q, mcand_d;
    logic             negative_q, negative_d;
    logic             done_q, done_d;
    logic             center_q;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             press;

    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            state_q    <= S_SEL;
            sel_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            mcand_q    <= '0;
            negative_q <= 1'b0;
            done_q     <= 1'b0;
            center_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            mcand_q    <= mcand_d;
            negative_q <= negative_d;
            done_q     <= done_d;
            center_q   <= Center;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        mcand_d    = mcand_q;
        negative_d = negative_q;
        cnt_d      = cnt_q;
        press      = Center & ~center_q;

        case (state_q)
            S_SEL: begin
                if (press) begin
                    sel_d   = SW[1:0];
                    state_d = S_A;
                end
            end
            S_A: begin
                if (press) begin
                    a_d     = SW;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    b_d        = SW;
                    cnt_d      = '0;
                    result_d   = '0;
                    negative_d = 1'b0;
                    mcand_d    = {{WIDTH{1'b0}}, a_q};
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                case (sel_q)
                    2'b00: begin
                        result_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
                        state_d  = S_SHOW;
                    end
                    2'b01: begin
                        if (a_q >= b_q) begin
                            result_d   = {{WIDTH{1'b0}}, a_q - b_q};
                            negative_d = 1'b0;
                        end else begin
                            result_d   = {{WIDTH{1'b0}}, b_q - a_q};
                            negative_d = 1'b1;
                        end
                        state_d = S_SHOW;
                    end
                    2'b10: begin
                        // One multiplier bit per cycle, LSB first; runs the full WIDTH cycles even for B=0.
                        if (b_q[cnt_q]) begin
                            result_d = result_q + mcand_q;
                        end
                        mcand_d = mcand_q << 1;
                        cnt_d   = cnt_q + SHW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_SHOW;
                        end
                    end
                    default: begin
                        result_d = {{WIDTH{1'b0}}, a_q >> b_q[SHW-1:0]};
                        state_d  = S_SHOW;
                    end
                endcase
            end
            S_SHOW: begin
                if (press) begin
                    sel_d      = '0;
                    a_d        = '0;
                    b_d        = '0;
                    result_d   = '0;
                    negative_d = 1'b0;
                    state_d    = S_SEL;
                end
            end
            default: begin
                state_d = S_SEL;
            end
        endcase

        done_d = (state_d == S_SHOW) && (state_q != S_SHOW);
    end

    assign result   = result_q;
    assign negative = negative_q;
    assign LED      = 4'b0001 << sel_q;
    assign busy     = (state_q == S_EXEC);
    assign done     = done_q;
    assign stage    = state_q;

endmodule
